bus_cdc_responder: RTL and testbench

- Destination-domain register responder that terminates the pulsed bus emitted by the CPU-to-module CDC bridge.
- Decodes one-cycle we/address/data pulses into a small register bank, an event/status block and a command queue to user logic.
- Returns read data exactly one cycle after the request, which is the cycle the bridge captures it.
- Drives zero on its read-data output at all other times so it can be OR-muxed with other responders.

---
 rtl/bus_cdc_responder.sv | 193 +++++++++++++++++++
 tb/tb_bus_cdc_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cdc_responder.sv
// Register responder behind the CPU-to-module CDC bridge pulsed bus.
// Optional command queue: define BUS_CDC_RESPONDER_CMDQ_EN.
module bus_cdc_responder #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h5253_5031,
  parameter int          CMD_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              bus_reset_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_address_i,
  input  logic [31:0]       bus_data_i,
  output logic [31:0]       bus_data_o,
  output logic [31:0]       ctrl_o,
  input  logic [7:0]        evt_i,
  output logic              irq_o,
  output logic              cmd_valid_o,
  output logic [31:0]       cmd_data_o,
  input  logic              cmd_ready_i
);

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SPAN =
    ADDR_W'(32'h14 + 4 * NUM_SCRATCH);
  localparam int PW =
    (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

  logic              clr;
  logic [ADDR_W-1:0] off;
  logic              hit;
  logic [6:0]        word;
  logic              wr;
  logic              rd;
  logic              wr_ctrl;
  logic              wr_stat;
  logic              wr_cnt;
  logic              push_req;
  logic              ovf_set;
  logic [31:0]       occ;

  logic [31:0] ctrl_q;
  logic [7:0]  evt_q;
  logic        ovf_q;
  logic [31:0] status;
  logic [31:0] w1c;
  logic [31:0] cnt_q;
  logic [31:0] scratch [NUM_SCRATCH];
  logic [31:0] scr_rd;
  logic [31:0] rdata;

  assign clr  = ~rst_n_i | bus_reset_i;
  assign off  = bus_address_i - BASE;
  assign hit  = (bus_address_i >= BASE)
              && (off < SPAN)
              && (bus_address_i[1:0] == 2'b00);
  assign word = off[8:2];
  assign wr   = hit & bus_we_i;
  assign rd   = hit & ~bus_we_i;

  assign wr_ctrl  = wr && (word == 7'd1);
  assign wr_stat  = wr && (word == 7'd2);
  assign wr_cnt   = wr && (word == 7'd3);
  assign push_req = wr && (word == 7'd4);

  assign w1c    = wr_stat ? bus_data_i : '0;
  assign status = {ovf_q, 23'b0, evt_q};
  assign ctrl_o = ctrl_q;
  assign irq_o  = ctrl_q[0] & (status != '0);

  // CTRL register
  always_ff @(posedge clk_i) begin
    if (clr)
      ctrl_q <= '0;
    else if (wr_ctrl)
      ctrl_q <= bus_data_i;
  end

  // Sticky status; a same-cycle set beats the W1C clear
  always_ff @(posedge clk_i) begin
    if (clr) begin
      evt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      evt_q <= (evt_q & ~w1c[7:0]) | evt_i;
      ovf_q <= (ovf_q & ~w1c[31]) | ovf_set;
    end
  end

  // Free-running counter, any write reloads zero
  always_ff @(posedge clk_i) begin
    if (clr || wr_cnt)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 32'd1;
  end

  // Scratch register bank
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (clr)
        scratch[i] <= '0;
      else if (wr && (word == 7'(5 + i)))
        scratch[i] <= bus_data_i;
    end
  end

  // Scratch read select
  always_comb begin
    scr_rd = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (word == 7'(5 + i))
        scr_rd = scratch[i];
    end
  end

  // Read mux; only valid when hit is set
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      word == 7'd0: rdata = ID_VALUE;
      word == 7'd1: rdata = ctrl_q;
      word == 7'd2: rdata = status;
      word == 7'd3: rdata = cnt_q;
      word == 7'd4: rdata = occ;
      default:      rdata = scr_rd;
    endcase
  end

  // One-cycle read return, zero otherwise for OR-muxing
  always_ff @(posedge clk_i) begin
    if (clr)
      bus_data_o <= '0;
    else if (rd)
      bus_data_o <= rdata;
    else
      bus_data_o <= '0;
  end

`ifdef BUS_CDC_RESPONDER_CMDQ_EN
  logic [31:0] mem [CMD_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = cnt[PW];
  assign pop     = cmd_valid_o & cmd_ready_i;
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & ~push_ok;

  assign cmd_valid_o = (cnt != '0);
  assign cmd_data_o  = mem[rp];
  assign occ         = 32'(cnt);

  // Queue pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      cnt <= cnt
           + {{PW{1'b0}}, push_ok}
           - {{PW{1'b0}}, pop};
    end
  end

  // Queue storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (!clr && push_ok)
      mem[wp] <= bus_data_i;
  end
`else
  logic unused_cmd;

  assign cmd_valid_o = 1'b0;
  assign cmd_data_o  = '0;
  assign ovf_set     = 1'b0;
  assign occ         = '0;
  assign unused_cmd  = cmd_ready_i ^ push_req;
`endif

endmodule

// File: tb/tb_bus_cdc_responder.sv
// Directed bench for bus_cdc_responder.
// Follows BUS_CDC_RESPONDER_CMDQ_EN like the design.
module tb_bus_cdc_responder;

  localparam logic [31:0] B = 32'h100;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        bus_reset_i;
  logic        bus_we_i;
  logic [31:0] bus_address_i;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o;
  logic [31:0] ctrl_o;
  logic [7:0]  evt_i;
  logic        irq_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_data_o;
  logic        cmd_ready_i;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  bus_cdc_responder #(
    .ADDR_W     (32),
    .BASE_ADDR  (B),
    .NUM_SCRATCH(4),
    .ID_VALUE   (32'h5253_5031),
    .CMD_DEPTH  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .bus_reset_i  (bus_reset_i),
    .bus_we_i     (bus_we_i),
    .bus_address_i(bus_address_i),
    .bus_data_i   (bus_data_i),
    .bus_data_o   (bus_data_o),
    .ctrl_o       (ctrl_o),
    .evt_i        (evt_i),
    .irq_o        (irq_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_data_o   (cmd_data_o),
    .cmd_ready_i  (cmd_ready_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus_we_i      = 1'b1;
    bus_address_i = a;
    bus_data_i    = d;
    tick();
    bus_we_i      = 1'b0;
    bus_address_i = '0;
    bus_data_i    = '0;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    bus_address_i = a;
    tick();
    bus_address_i = '0;
    chk(tag, bus_data_o, exp);
  endtask

  initial begin
    rst_n_i       = 1'b0;
    bus_reset_i   = 1'b0;
    bus_we_i      = 1'b0;
    bus_address_i = '0;
    bus_data_i    = '0;
    evt_i         = '0;
    cmd_ready_i   = 1'b0;
    tick();
    tick();
    chk("rst_rdata", bus_data_o, 32'h0);
    chk("rst_ctrl", ctrl_o, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_valid", 32'(cmd_valid_o), 32'h0);
    rst_n_i = 1'b1;

    rd("id", B, 32'h5253_5031);
    tick();
    chk("id_after", bus_data_o, 32'h0);

    wr(B + 32'h04, 32'h1);
    chk("ctrl1", ctrl_o, 32'h1);
    chk("irq_quiet", 32'(irq_o), 32'h0);
    evt_i = 8'h05;
    tick();
    evt_i = 8'h00;
    rd("stat05", B + 32'h08, 32'h05);
    chk("irq_on", 32'(irq_o), 32'h1);
    wr(B + 32'h08, 32'h01);
    rd("stat_w1c", B + 32'h08, 32'h04);
    evt_i = 8'h04;
    wr(B + 32'h08, 32'h04);
    evt_i = 8'h00;
    rd("set_wins", B + 32'h08, 32'h04);
    wr(B + 32'h08, 32'h04);
    rd("stat_clr", B + 32'h08, 32'h00);
    chk("irq_off", 32'(irq_o), 32'h0);

    wr(B + 32'h0C, 32'h1234);
    rd("cnt_n1", B + 32'h0C, 32'h0);
    tick();
    rd("cnt_n3", B + 32'h0C, 32'h2);

    wr(B + 32'h14, 32'hAAAA_0001);
    wr(B + 32'h20, 32'hBBBB_0004);
    bus_address_i = B + 32'h14;
    tick();
    bus_address_i = B + 32'h20;
    chk("scr0_b2b", bus_data_o, 32'hAAAA_0001);
    tick();
    bus_address_i = '0;
    chk("scr3_b2b", bus_data_o, 32'hBBBB_0004);
    tick();
    chk("b2b_idle", bus_data_o, 32'h0);

    rd("misalign", B + 32'h02, 32'h0);
    rd("above", B + 32'h24, 32'h0);
    rd("below", B - 32'h04, 32'h0);
    wr(B + 32'h15, 32'hFFFF_FFFF);
    wr(B + 32'h24, 32'hFFFF_FFFF);
    rd("scr0_kept", B + 32'h14, 32'hAAAA_0001);

`ifdef BUS_CDC_RESPONDER_CMDQ_EN
    for (int i = 0; i < 5; i++)
      wr(B + 32'h10, 32'hC0DE_0000 + 32'(i));
    chk("q_valid", 32'(cmd_valid_o), 32'h1);
    chk("q_head", cmd_data_o, 32'hC0DE_0000);
    rd("q_occ4", B + 32'h10, 32'h4);
    rd("q_ovf", B + 32'h08, 32'h8000_0000);
    wr(B + 32'h08, 32'h8000_0000);
    rd("ovf_clr", B + 32'h08, 32'h0);
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_v", 32'(cmd_valid_o), 32'h1);
      chk("drain_d", cmd_data_o,
          32'hC0DE_0000 + 32'(i));
      tick();
    end
    cmd_ready_i = 1'b0;
    chk("drained", 32'(cmd_valid_o), 32'h0);

    for (int i = 0; i < 4; i++)
      wr(B + 32'h10, 32'hA000 + 32'(i));
    rd("full4", B + 32'h10, 32'h4);
    cmd_ready_i = 1'b1;
    wr(B + 32'h10, 32'hA004);
    cmd_ready_i = 1'b0;
    rd("pp_occ", B + 32'h10, 32'h4);
    rd("pp_noovf", B + 32'h08, 32'h0);
    chk("pp_head", cmd_data_o, 32'hA001);
    cmd_ready_i = 1'b1;
    tick();
    cmd_ready_i = 1'b0;
    rd("occ3", B + 32'h10, 32'h3);
    wr(B + 32'h04, 32'hFF);
    chk("ctrl_ff", ctrl_o, 32'hFF);
    bus_reset_i = 1'b1;
    tick();
    bus_reset_i = 1'b0;
    chk("br_valid", 32'(cmd_valid_o), 32'h0);
    chk("br_ctrl", ctrl_o, 32'h0);
    rd("br_occ", B + 32'h10, 32'h0);
`else
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++)
      wr(B + 32'h10, 32'hC0DE_0000 + 32'(i));
    chk("nq_valid", 32'(cmd_valid_o), 32'h0);
    chk("nq_data", cmd_data_o, 32'h0);
    rd("nq_occ", B + 32'h10, 32'h0);
    rd("nq_noovf", B + 32'h08, 32'h0);
    cmd_ready_i = 1'b0;
    wr(B + 32'h04, 32'hFF);
    chk("ctrl_ff", ctrl_o, 32'hFF);
    bus_reset_i = 1'b1;
    tick();
    bus_reset_i = 1'b0;
    chk("br_ctrl", ctrl_o, 32'h0);
    chk("br_valid", 32'(cmd_valid_o), 32'h0);
`endif

    wr(B + 32'h04, 32'h3);
    bus_address_i = B;
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    bus_address_i = '0;
    chk("rst_kill_rd", bus_data_o, 32'h0);
    chk("rst_ctrl2", ctrl_o, 32'h0);
    rd("scr_rst", B + 32'h14, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
